// File: rtl/proc_ctrl_pkg.sv
// Shared opcodes, FSM states, ALU codes and decoded-op record for the
// multi-cycle controller of the 24-bit processor.
package proc_ctrl_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h06;
    localparam logic [5:0] OP_SW   = 6'h07;
    localparam logic [5:0] OP_BEQ  = 6'h08;
    localparam logic [5:0] OP_JMP  = 6'h09;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Unknown ops decode as CL_NOP with legal=0.
    typedef enum logic [2:0] {
        CL_NOP,
        CL_HALT,
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       reg_dst_rt;
        logic       wb_mem;
        logic       legal;
    } op_info_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational op-field decoder: class, ALU function and datapath selects.
module ctrl_op_decode
    import proc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    output op_info_t   o_info
);

    always_comb begin
        o_info = '{cls: CL_NOP, alu_op: ALU_ADD, alu_src_imm: 1'b0,
                   reg_dst_rt: 1'b0, wb_mem: 1'b0, legal: 1'b1};
        case (i_op)
            OP_NOP:  o_info.cls = CL_NOP;
            OP_HALT: o_info.cls = CL_HALT;
            OP_ADD:  o_info.cls = CL_ALU;
            OP_SUB: begin
                o_info.cls    = CL_ALU;
                o_info.alu_op = ALU_SUB;
            end
            OP_AND: begin
                o_info.cls    = CL_ALU;
                o_info.alu_op = ALU_AND;
            end
            OP_OR: begin
                o_info.cls    = CL_ALU;
                o_info.alu_op = ALU_OR;
            end
            OP_ADDI: begin
                o_info.cls         = CL_ALU;
                o_info.alu_src_imm = 1'b1;
                o_info.reg_dst_rt  = 1'b1;
            end
            OP_LW: begin
                o_info.cls         = CL_LOAD;
                o_info.alu_src_imm = 1'b1;
                o_info.reg_dst_rt  = 1'b1;
                o_info.wb_mem      = 1'b1;
            end
            OP_SW: begin
                o_info.cls         = CL_STORE;
                o_info.alu_src_imm = 1'b1;
            end
            OP_BEQ: begin
                o_info.cls    = CL_BRANCH;
                o_info.alu_op = ALU_SUB;
            end
            OP_JMP:  o_info.cls = CL_JUMP;
            default: o_info.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with req/ready memory port.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control
    import proc_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       reg_write,
    output logic       reg_dst_rt,
    output logic       alu_src_imm,
    output logic [2:0] alu_op,
    output logic       wb_mem,
    output logic       illegal,
    output logic       halted,
    output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    state_t   r_state;
    state_t   w_next;
    logic     r_fetch_busy;
    logic     w_fetch_busy_nxt;
    op_info_t w_info;

    ctrl_op_decode u_decode (
        .i_op   (op),
        .o_info (w_info)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_fetch_busy <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_fetch_busy <= w_fetch_busy_nxt;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_fetch_busy_nxt = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        addr_sel         = 1'b0;
        ir_load          = 1'b0;
        pc_inc           = 1'b0;
        pc_load          = 1'b0;
        reg_write        = 1'b0;
        reg_dst_rt       = 1'b0;
        alu_src_imm      = 1'b0;
        alu_op           = ALU_ADD;
        wb_mem           = 1'b0;
        illegal          = 1'b0;
        halted           = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // run only matters before the request starts; rst_n gating keeps
                // every output low while reset is held.
                if (rst_n && (run || r_fetch_busy)) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        w_next  = ST_DECODE;
                    end else begin
                        w_fetch_busy_nxt = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                illegal = !w_info.legal;
                case (w_info.cls)
                    CL_NOP:  w_next = (!w_info.legal && ILLEGAL_HALT) ? ST_HALT : ST_FETCH;
                    CL_HALT: w_next = ST_HALT;
                    default: w_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                alu_op      = w_info.alu_op;
                alu_src_imm = w_info.alu_src_imm;
                case (w_info.cls)
                    CL_ALU:            w_next = ST_WB;
                    CL_LOAD, CL_STORE: w_next = ST_MEM;
                    CL_BRANCH: begin
                        pc_load = zero;
                        w_next  = ST_FETCH;
                    end
                    CL_JUMP: begin
                        pc_load = 1'b1;
                        w_next  = ST_FETCH;
                    end
                    default:           w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (w_info.cls == CL_STORE);
                if (mem_ready) begin
                    w_next = (w_info.cls == CL_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst_rt = w_info.reg_dst_rt;
                wb_mem     = w_info.wb_mem;
                w_next     = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_next = ST_FETCH;
        endcase
    end

    assign state = r_state;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
        end else begin
            if (r_state != ST_HALT) r_cycle_count <= r_cycle_count + 32'd1;
            if (r_state == ST_DECODE) r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are
// queued by the stimulus and compared by a negedge monitor.
module tb_multicycle_control;

    localparam int W = 18;

    localparam logic [5:0] T_NOP = 6'h00, T_ADD = 6'h01, T_SUB = 6'h02, T_AND = 6'h03;
    localparam logic [5:0] T_OR  = 6'h04, T_ADDI = 6'h05, T_LW = 6'h06, T_SW = 6'h07;
    localparam logic [5:0] T_BEQ = 6'h08, T_JMP = 6'h09, T_HALT = 6'h3F, T_BAD = 6'h2A;

    localparam logic [14:0] C_REQ = 15'h4000, C_WE  = 15'h2000, C_ASEL = 15'h1000;
    localparam logic [14:0] C_IRL = 15'h0800, C_PCI = 15'h0400, C_PCL  = 15'h0200;
    localparam logic [14:0] C_RW  = 15'h0100, C_RDT = 15'h0080, C_IMM  = 15'h0040;
    localparam logic [14:0] C_WBM = 15'h0004, C_ILL = 15'h0002, C_HLT  = 15'h0001;
    localparam logic [14:0] C_F   = C_REQ | C_IRL | C_PCI;

    logic clk, rst_n, run, run_h, zero, mem_ready;
    logic [5:0] op;

    logic mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_write;
    logic reg_dst_rt, alu_src_imm, wb_mem, illegal, halted;
    logic [2:0] alu_op, state;

    logic mem_req_h, mem_we_h, addr_sel_h, ir_load_h, pc_inc_h, pc_load_h, reg_write_h;
    logic reg_dst_rt_h, alu_src_imm_h, wb_mem_h, illegal_h, halted_h;
    logic [2:0] alu_op_h, state_h;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count, cycle_count_h, instr_count_h;
`endif

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_h_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_seq = 0;
    int n_seq_h = 0;

    multicycle_control #(.ILLEGAL_HALT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write), .reg_dst_rt(reg_dst_rt),
        .alu_src_imm(alu_src_imm), .alu_op(alu_op), .wb_mem(wb_mem), .illegal(illegal),
        .halted(halted), .state(state)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    multicycle_control #(.ILLEGAL_HALT(1'b1)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .run(run_h), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_h), .mem_we(mem_we_h), .addr_sel(addr_sel_h), .ir_load(ir_load_h),
        .pc_inc(pc_inc_h), .pc_load(pc_load_h), .reg_write(reg_write_h),
        .reg_dst_rt(reg_dst_rt_h), .alu_src_imm(alu_src_imm_h), .alu_op(alu_op_h),
        .wb_mem(wb_mem_h), .illegal(illegal_h), .halted(halted_h), .state(state_h)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_count(cycle_count_h), .instr_count(instr_count_h)
`endif
    );

    wire [W-1:0] snap = {state, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                         reg_write, reg_dst_rt, alu_src_imm, alu_op, wb_mem, illegal, halted};
    wire [W-1:0] snap_h = {state_h, mem_req_h, mem_we_h, addr_sel_h, ir_load_h, pc_inc_h,
                           pc_load_h, reg_write_h, reg_dst_rt_h, alu_src_imm_h, alu_op_h,
                           wb_mem_h, illegal_h, halted_h};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [14:0] ctl);
        return {st, ctl};
    endfunction

    function automatic logic [14:0] alu(input logic [2:0] a);
        return {9'b0, a, 3'b0};
    endfunction

    // driver tasks: inputs for one cycle plus that cycle's expected word
    task automatic cyc(input logic [5:0] o, input logic r, input logic rdy, input logic z,
                       input logic [W-1:0] e);
        @(posedge clk);
        #1;
        op = o; run = r; mem_ready = rdy; zero = z;
        exp_q.push_back(e);
    endtask

    task automatic cyc_h(input logic [5:0] o, input logic r, input logic rdy,
                         input logic [W-1:0] e);
        @(posedge clk);
        #1;
        op = o; run_h = r; mem_ready = rdy;
        exp_h_q.push_back(e);
    endtask

    task automatic fetch_decode(input logic [5:0] o, input logic [14:0] dec_ctl);
        cyc(o, 1'b1, 1'b1, 1'b0, ev(3'd0, C_F));
        cyc(o, 1'b1, 1'b1, 1'b0, ev(3'd1, dec_ctl));
    endtask

    task automatic alu_instr(input logic [5:0] o, input logic [14:0] ex_ctl,
                             input logic [14:0] wb_ctl);
        fetch_decode(o, 15'h0);
        cyc(o, 1'b1, 1'b1, 1'b0, ev(3'd2, ex_ctl));
        cyc(o, 1'b1, 1'b1, 1'b0, ev(3'd4, wb_ctl));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            n_seq++;
            n_checks++;
            if (snap !== e) begin
                n_errors++;
                $display("FAIL cycle%0d {state,ctl}: got %05h expected %05h", n_seq, snap, e);
            end
        end
        if (exp_h_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_h_q.pop_front();
            n_seq_h++;
            n_checks++;
            if (snap_h !== e) begin
                n_errors++;
                $display("FAIL halt_inst cycle%0d {state,ctl}: got %05h expected %05h",
                         n_seq_h, snap_h, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; run_h = 1'b0; op = T_ADD; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {14'b0, snap}, {14'b0, ev(3'd0, 15'h0)});
        run = 1'b0;
        #2 rst_n = 1'b1;

        // ADD: 0,1,2,4
        alu_instr(T_ADD, alu(3'd0), C_RW);
        cyc(T_ADD, 1'b0, 1'b1, 1'b0, ev(3'd0, 15'h0));
        // fetch wait; run dropping mid-handshake must not cancel it
        cyc(T_NOP, 1'b1, 1'b0, 1'b0, ev(3'd0, C_REQ));
        cyc(T_NOP, 1'b0, 1'b0, 1'b0, ev(3'd0, C_REQ));
        cyc(T_NOP, 1'b0, 1'b1, 1'b0, ev(3'd0, C_F));
        cyc(T_NOP, 1'b0, 1'b1, 1'b0, ev(3'd1, 15'h0));
        // LW with 3 wait states in MEM
        fetch_decode(T_LW, 15'h0);
        cyc(T_LW, 1'b1, 1'b1, 1'b0, ev(3'd2, C_IMM));
        repeat (3) cyc(T_LW, 1'b1, 1'b0, 1'b0, ev(3'd3, C_REQ | C_ASEL));
        cyc(T_LW, 1'b1, 1'b1, 1'b0, ev(3'd3, C_REQ | C_ASEL));
        cyc(T_LW, 1'b1, 1'b1, 1'b0, ev(3'd4, C_RW | C_RDT | C_WBM));
        // SW
        fetch_decode(T_SW, 15'h0);
        cyc(T_SW, 1'b1, 1'b1, 1'b0, ev(3'd2, C_IMM));
        cyc(T_SW, 1'b1, 1'b1, 1'b0, ev(3'd3, C_REQ | C_WE | C_ASEL));
        // BEQ taken / not taken, JMP
        fetch_decode(T_BEQ, 15'h0);
        cyc(T_BEQ, 1'b1, 1'b1, 1'b1, ev(3'd2, alu(3'd1) | C_PCL));
        fetch_decode(T_BEQ, 15'h0);
        cyc(T_BEQ, 1'b1, 1'b1, 1'b0, ev(3'd2, alu(3'd1)));
        fetch_decode(T_JMP, 15'h0);
        cyc(T_JMP, 1'b1, 1'b1, 1'b0, ev(3'd2, C_PCL));
        // remaining ALU ops
        alu_instr(T_SUB, alu(3'd1), C_RW);
        alu_instr(T_AND, alu(3'd2), C_RW);
        alu_instr(T_OR, alu(3'd3), C_RW);
        alu_instr(T_ADDI, C_IMM, C_RW | C_RDT);
        // illegal op skipped
        fetch_decode(T_BAD, C_ILL);
        cyc(T_BAD, 1'b0, 1'b1, 1'b0, ev(3'd0, 15'h0));
        // illegal op halts the ILLEGAL_HALT=1 instance
        cyc_h(T_BAD, 1'b1, 1'b1, ev(3'd0, C_F));
        cyc_h(T_BAD, 1'b1, 1'b1, ev(3'd1, C_ILL));
        repeat (20) cyc_h(T_BAD, 1'b1, 1'b1, ev(3'd5, C_HLT));
        run_h = 1'b0;

        // reset in the middle of a MEM wait
        fetch_decode(T_LW, 15'h0);
        cyc(T_LW, 1'b1, 1'b1, 1'b0, ev(3'd2, C_IMM));
        cyc(T_LW, 1'b1, 1'b0, 1'b0, ev(3'd3, C_REQ | C_ASEL));
        @(posedge clk);
        #1 mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mid_mem_state", {29'b0, state}, 32'd0);
        chk("rst_mid_mem_all", {14'b0, snap}, {14'b0, ev(3'd0, 15'h0)});
        chk("rst_halt_inst", {14'b0, snap_h}, {14'b0, ev(3'd0, 15'h0)});

        // release straight into a fetch: ADD, SW, HALT
        @(posedge clk);
        #1;
        rst_n = 1'b1; op = T_ADD; run = 1'b1; mem_ready = 1'b1;
        exp_q.push_back(ev(3'd0, C_F));
        cyc(T_ADD, 1'b1, 1'b1, 1'b0, ev(3'd1, 15'h0));
        cyc(T_ADD, 1'b1, 1'b1, 1'b0, ev(3'd2, alu(3'd0)));
        cyc(T_ADD, 1'b1, 1'b1, 1'b0, ev(3'd4, C_RW));
        fetch_decode(T_SW, 15'h0);
        cyc(T_SW, 1'b1, 1'b1, 1'b0, ev(3'd2, C_IMM));
        cyc(T_SW, 1'b1, 1'b1, 1'b0, ev(3'd3, C_REQ | C_WE | C_ASEL));
        fetch_decode(T_HALT, 15'h0);
        cyc(T_HALT, 1'b1, 1'b1, 1'b0, ev(3'd5, C_HLT));
`ifdef CTRL_PERF_CNT_EN
        chk("instr_count", instr_count, 32'd3);
        chk("cycle_count", cycle_count, 32'd10);
`endif
        repeat (3) cyc(T_ADD, 1'b1, 1'b1, 1'b0, ev(3'd5, C_HLT));
`ifdef CTRL_PERF_CNT_EN
        chk("cycle_count_frozen", cycle_count, 32'd10);
`endif

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size() + exp_h_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
